// File: rtl/wb_cpu_bus_arbiter.sv
// Round-robin arbiter merging the CPU instruction (iwb) and data (dwb) Wishbone B3 masters onto one port.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_cpu_bus_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,

    input  logic [ADDRESS_WIDTH-1:0] iwb_adr_i,
    input  logic [DATA_WIDTH-1:0]    iwb_dat_i,
    input  logic [3:0]               iwb_sel_i,
    input  logic [2:0]               iwb_cti_i,
    input  logic [1:0]               iwb_bte_i,
    input  logic                     iwb_cyc_i,
    input  logic                     iwb_stb_i,
    input  logic                     iwb_we_i,
    output logic                     iwb_ack_o,
    output logic                     iwb_err_o,
    output logic                     iwb_rty_o,
    output logic [DATA_WIDTH-1:0]    iwb_dat_o,

    input  logic [ADDRESS_WIDTH-1:0] dwb_adr_i,
    input  logic [DATA_WIDTH-1:0]    dwb_dat_i,
    input  logic [3:0]               dwb_sel_i,
    input  logic [2:0]               dwb_cti_i,
    input  logic [1:0]               dwb_bte_i,
    input  logic                     dwb_cyc_i,
    input  logic                     dwb_stb_i,
    input  logic                     dwb_we_i,
    output logic                     dwb_ack_o,
    output logic                     dwb_err_o,
    output logic                     dwb_rty_o,
    output logic [DATA_WIDTH-1:0]    dwb_dat_o,

    output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0]    wb_dat_o,
    output logic [3:0]               wb_sel_o,
    output logic [2:0]               wb_cti_o,
    output logic [1:0]               wb_bte_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     wb_rty_i,
    input  logic [DATA_WIDTH-1:0]    wb_dat_i,

    output logic                     timeout_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_cpu_bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;     // 1: dwb held the most recent grant
    logic   gnt_i, gnt_d;
    logic   raw_cyc, raw_stb;
    logic   timeout_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (iwb_cyc_i && dwb_cyc_i)
                    state_d = last_d_q ? GNT_I : GNT_D;
                else if (dwb_cyc_i)
                    state_d = GNT_D;
                else if (iwb_cyc_i)
                    state_d = GNT_I;
            end
            GNT_I: begin
                if (!iwb_cyc_i) begin
                    last_d_d = 1'b0;
                    state_d  = dwb_cyc_i ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!dwb_cyc_i) begin
                    last_d_d = 1'b1;
                    state_d  = iwb_cyc_i ? GNT_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        wb_adr_o  = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = '0;
        wb_bte_o  = '0;
        wb_we_o   = 1'b0;
        raw_cyc   = 1'b0;
        raw_stb   = 1'b0;
        iwb_ack_o = 1'b0;
        iwb_rty_o = 1'b0;
        dwb_ack_o = 1'b0;
        dwb_rty_o = 1'b0;
        iwb_dat_o = '0;
        dwb_dat_o = '0;
        case (state_q)
            GNT_I: begin
                gnt_i     = 1'b1;
                wb_adr_o  = iwb_adr_i;
                wb_dat_o  = iwb_dat_i;
                wb_sel_o  = iwb_sel_i;
                wb_cti_o  = iwb_cti_i;
                wb_bte_o  = iwb_bte_i;
                wb_we_o   = iwb_we_i;
                raw_cyc   = iwb_cyc_i;
                raw_stb   = iwb_stb_i;
                iwb_ack_o = wb_ack_i;
                iwb_rty_o = wb_rty_i;
                iwb_dat_o = wb_dat_i;
                dwb_dat_o = wb_dat_i;
            end
            GNT_D: begin
                gnt_d     = 1'b1;
                wb_adr_o  = dwb_adr_i;
                wb_dat_o  = dwb_dat_i;
                wb_sel_o  = dwb_sel_i;
                wb_cti_o  = dwb_cti_i;
                wb_bte_o  = dwb_bte_i;
                wb_we_o   = dwb_we_i;
                raw_cyc   = dwb_cyc_i;
                raw_stb   = dwb_stb_i;
                dwb_ack_o = wb_ack_i;
                dwb_rty_o = wb_rty_i;
                iwb_dat_o = wb_dat_i;
                dwb_dat_o = wb_dat_i;
            end
            default: ;
        endcase
    end

    // Errors and cyc/stb are kept out of the mux so the watchdog can override them without a loop
    assign wb_cyc_o  = raw_cyc & ~timeout_hit;
    assign wb_stb_o  = raw_stb & ~timeout_hit;
    assign iwb_err_o = gnt_i & (wb_err_i | timeout_hit);
    assign dwb_err_o = gnt_d & (wb_err_i | timeout_hit);
    assign timeout_o = timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        resp_any;
    logic        stall;

    assign resp_any    = wb_ack_i | wb_err_i | wb_rty_i;
    assign stall       = raw_cyc & raw_stb & ~resp_any;
    // Counter holds the number of completed stall cycles, so the hit lands on the Nth stall cycle
    assign timeout_hit = stall && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stall_cnt <= '0;
        else if (timeout_hit || resp_any || (state_d != state_q))
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Scoreboard bench for wb_cpu_bus_arbiter: directed stimulus queues expected responses, a monitor checks them.
module tb_wb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iwb_adr, iwb_dat, dwb_adr, dwb_dat;
    logic [3:0]  iwb_sel, dwb_sel;
    logic [2:0]  iwb_cti, dwb_cti;
    logic [1:0]  iwb_bte, dwb_bte;
    logic        iwb_cyc, iwb_stb, iwb_we, dwb_cyc, dwb_stb, dwb_we;
    logic        iwb_ack_o, iwb_err_o, iwb_rty_o, dwb_ack_o, dwb_err_o, dwb_rty_o;
    logic [31:0] iwb_dat_o, dwb_dat_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic        wb_ack, wb_err, wb_rty;
    logic [31:0] wb_dat_i;
    logic        timeout_o;

    always #5 clk = ~clk;

    wb_cpu_bus_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i    (clk),      .rst_n_i  (rst_n),
        .iwb_adr_i(iwb_adr),  .iwb_dat_i(iwb_dat),  .iwb_sel_i(iwb_sel),
        .iwb_cti_i(iwb_cti),  .iwb_bte_i(iwb_bte),  .iwb_cyc_i(iwb_cyc),
        .iwb_stb_i(iwb_stb),  .iwb_we_i (iwb_we),   .iwb_ack_o(iwb_ack_o),
        .iwb_err_o(iwb_err_o), .iwb_rty_o(iwb_rty_o), .iwb_dat_o(iwb_dat_o),
        .dwb_adr_i(dwb_adr),  .dwb_dat_i(dwb_dat),  .dwb_sel_i(dwb_sel),
        .dwb_cti_i(dwb_cti),  .dwb_bte_i(dwb_bte),  .dwb_cyc_i(dwb_cyc),
        .dwb_stb_i(dwb_stb),  .dwb_we_i (dwb_we),   .dwb_ack_o(dwb_ack_o),
        .dwb_err_o(dwb_err_o), .dwb_rty_o(dwb_rty_o), .dwb_dat_o(dwb_dat_o),
        .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel_o),
        .wb_cti_o (wb_cti_o), .wb_bte_o (wb_bte_o), .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o), .wb_we_o  (wb_we_o),  .wb_ack_i (wb_ack),
        .wb_err_i (wb_err),   .wb_rty_i (wb_rty),   .wb_dat_i (wb_dat_i),
        .timeout_o(timeout_o)
    );

    // Flag bits: {timeout, d_rty, d_err, d_ack, i_rty, i_err, i_ack}
    localparam logic [6:0] F_I_ACK = 7'b0000001;
    localparam logic [6:0] F_I_ERR = 7'b0000010;
    localparam logic [6:0] F_D_ACK = 7'b0001000;
    localparam logic [6:0] F_D_ERR = 7'b0010000;
    localparam logic [6:0] F_TO    = 7'b1000000;

    typedef struct packed {
        logic [6:0]  flags;
        logic [31:0] dat;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [6:0] flags, input logic [31:0] dat);
        resp_t r;
        r.flags = flags;
        r.dat   = dat;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [6:0] f;
        resp_t      e;
        f = {timeout_o, dwb_rty_o, dwb_err_o, dwb_ack_o, iwb_rty_o, iwb_err_o, iwb_ack_o};
        if ((|f) === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got flags %b, none expected", f);
            end else begin
                e = exp_q.pop_front();
                check("resp_flags", {25'b0, f}, {25'b0, e.flags});
                check("resp_iwb_dat", iwb_dat_o, e.dat);
                check("resp_dwb_dat", dwb_dat_o, e.dat);
            end
        end
    end

    initial begin
        int errs;
        errs  = 0;
        rst_n = 1'b0;
        iwb_adr = '0; iwb_dat = '0; iwb_sel = '0; iwb_cti = '0; iwb_bte = '0;
        iwb_cyc = 1'b0; iwb_stb = 1'b0; iwb_we = 1'b0;
        dwb_adr = '0; dwb_dat = '0; dwb_sel = '0; dwb_cti = '0; dwb_bte = '0;
        dwb_cyc = 1'b0; dwb_stb = 1'b0; dwb_we = 1'b0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_dat_i = '0;

        // Reset state
        @(negedge clk);
        check("rst_wb_cyc", wb_cyc_o, 0);
        check("rst_wb_stb", wb_stb_o, 0);
        check("rst_wb_adr", wb_adr_o, 0);
        check("rst_timeout", timeout_o, 0);
        tick();
        rst_n = 1'b1;

        // 1: dwb single read
        dwb_adr = 32'h100; dwb_sel = 4'hF; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        @(negedge clk);
        check("t1_no_cyc_before_grant", wb_cyc_o, 0);
        tick();
        @(negedge clk);
        check("t1_cyc_granted", wb_cyc_o, 1);
        check("t1_adr", wb_adr_o, 32'h100);
        check("t1_sel", wb_sel_o, 4'hF);
        tick();
        wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
        expect_resp(F_D_ACK, 32'hDEADBEEF);
        tick();
        wb_ack = 1'b0; wb_dat_i = '0; dwb_cyc = 1'b0; dwb_stb = 1'b0;
        tick();
        @(negedge clk);
        check("t1_idle_after", wb_cyc_o, 0);

        // 2: simultaneous requests after reset alternate D, I, D
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        iwb_adr = 32'h2000; dwb_adr = 32'h3000;
        iwb_cyc = 1'b1; iwb_stb = 1'b1; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        tick();
        @(negedge clk);
        check("t2_first_gnt_d", wb_adr_o, 32'h3000);
        tick();
        wb_ack = 1'b1; wb_dat_i = 32'h11111111;
        expect_resp(F_D_ACK, 32'h11111111);
        tick();
        wb_ack = 1'b0; dwb_cyc = 1'b0; dwb_stb = 1'b0;
        @(negedge clk);
        check("t2_release_cycle", wb_cyc_o, 0);
        tick();
        @(negedge clk);
        check("t2_then_i_adr", wb_adr_o, 32'h2000);
        check("t2_then_i_cyc", wb_cyc_o, 1);
        tick();
        wb_ack = 1'b1; wb_dat_i = 32'h22222222;
        expect_resp(F_I_ACK, 32'h22222222);
        tick();
        wb_ack = 1'b0; iwb_cyc = 1'b0; iwb_stb = 1'b0;
        tick();
        iwb_cyc = 1'b1; iwb_stb = 1'b1; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        @(negedge clk);
        check("t2_idle_gap", wb_cyc_o, 0);
        tick();
        @(negedge clk);
        check("t2_repeat_d", wb_adr_o, 32'h3000);
        tick();
        iwb_cyc = 1'b0; iwb_stb = 1'b0; dwb_cyc = 1'b0; dwb_stb = 1'b0;
        tick();

        // 3: iwb 4-beat burst is not split by a pending dwb request
        iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h200; iwb_cti = 3'b010;
        tick();
        dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_adr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            iwb_adr  = 32'h200 + 32'(4 * k);
            iwb_cti  = (k == 3) ? 3'b111 : 3'b010;
            wb_ack   = 1'b1;
            wb_dat_i = 32'hA0000000 + 32'(k);
            expect_resp(F_I_ACK, 32'hA0000000 + 32'(k));
            @(negedge clk);
            check("t3_burst_adr", wb_adr_o, 32'h200 + 32'(4 * k));
            check("t3_burst_cti", wb_cti_o, (k == 3) ? 32'd7 : 32'd2);
            tick();
        end
        wb_ack = 1'b0; iwb_cyc = 1'b0; iwb_stb = 1'b0;
        @(negedge clk);
        check("t3_no_d_during_release", wb_cyc_o, 0);
        tick();
        @(negedge clk);
        check("t3_d_next_adr", wb_adr_o, 32'h400);
        check("t3_d_next_cyc", wb_cyc_o, 1);

        // 4: error during dwb write
        tick();
        dwb_we = 1'b1; dwb_dat = 32'hCAFEF00D; wb_err = 1'b1; wb_dat_i = '0;
        expect_resp(F_D_ERR, 32'h0);
        @(negedge clk);
        check("t4_we", wb_we_o, 1);
        check("t4_wdat", wb_dat_o, 32'hCAFEF00D);
        tick();
        wb_err = 1'b0; dwb_stb = 1'b0;
        @(negedge clk);
        check("t4_grant_held", wb_cyc_o, 1);
        tick();
        dwb_cyc = 1'b0; dwb_we = 1'b0;
        tick();
        @(negedge clk);
        check("t4_released", wb_cyc_o, 0);

        // 5: asynchronous reset mid-burst
        iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h500; iwb_cti = 3'b010;
        tick();
        @(negedge clk);
        check("t5_granted", wb_cyc_o, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_cyc", wb_cyc_o, 0);
        check("t5_async_stb", wb_stb_o, 0);
        check("t5_async_adr", wb_adr_o, 0);
        iwb_cyc = 1'b0; iwb_stb = 1'b0;
        tick();
        rst_n = 1'b1;
        dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_adr = 32'h600;
        @(negedge clk);
        check("t5_fresh_wait", wb_cyc_o, 0);
        tick();
        @(negedge clk);
        check("t5_fresh_cyc", wb_cyc_o, 1);
        check("t5_fresh_adr", wb_adr_o, 32'h600);
        tick();
        dwb_cyc = 1'b0; dwb_stb = 1'b0;
        tick();
        tick();

        // 6: slave never responds
`ifdef WB_ARB_TIMEOUT_EN
        iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h700; wb_dat_i = '0;
        expect_resp(F_TO | F_I_ERR, 32'h0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t6_cyc_forcing", wb_cyc_o, (k == 8) ? 32'd0 : 32'd1);
            tick();
        end
        iwb_cyc = 1'b0; iwb_stb = 1'b0;
        tick();
`else
        iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_adr = 32'h700;
        tick();
        repeat (1000) begin
            @(negedge clk);
            if (iwb_err_o || timeout_o) errs++;
        end
        check("t6_no_error_count", 32'(errs), 0);
        check("t6_still_waiting", wb_cyc_o, 1);
        tick();
        iwb_cyc = 1'b0; iwb_stb = 1'b0;
        tick();
`endif

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
